// File: rtl/spinet_pkg.sv
// Shared packet layout for the spinet SPI-to-ring packet network.
// A slot/packet is a flat 16-bit word; the helpers pull out the routing fields.
package spinet_pkg;
    localparam int PKT_W   = 16;
    localparam int ADDR_W  = 3;
    localparam int VALID   = 15;
    localparam int RSVD    = 14;
    localparam int DST_HI  = 13;
    localparam int DST_LO  = 11;
    localparam int SRC_HI  = 10;
    localparam int SRC_LO  = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    function automatic logic [ADDR_W-1:0] pkt_dst(input logic [PKT_W-1:0] w);
        return w[DST_HI:DST_LO];
    endfunction

    function automatic logic [PKT_W-1:0] pkt_stamp_src(input logic [PKT_W-1:0] w,
                                                       input logic [ADDR_W-1:0] src);
        logic [PKT_W-1:0] r;
        r = w;
        r[SRC_HI:SRC_LO] = src;
        return r;
    endfunction
endpackage

// File: rtl/spinet_node.sv
// One spinet node: mode-0 SPI slave with input synchronisers, one-word tx/rx
// buffers, and the capture/inject/pass decision for its ring slot.
module spinet_node
    import spinet_pkg::*;
#(
    parameter int N       = 6,
    parameter int NODE_ID = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mosi,
    input  logic             sck,
    input  logic             ss,
    output logic             miso,
    output logic             txrdy,
    output logic             rxrdy,
    input  logic [PKT_W-1:0] slot_in,
    output logic [PKT_W-1:0] slot_out
);
    logic [1:0]       sck_sy, ss_sy, mosi_sy;
    logic             sck_d, ss_d;
    logic             sck_s, ss_s, mosi_s;
    logic [PKT_W-1:0] shift, tx_buf, rx_buf;
    logic [4:0]       cnt;
    logic             tx_full, rx_full;
    logic             ss_fall, ss_rise, sck_rise, accept, cap, inj, dst_ok;

    assign sck_s  = sck_sy[1];
    assign ss_s   = ss_sy[1];
    assign mosi_s = mosi_sy[1];

    // Select resets to idle-high so a reset mid-transfer restarts cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sy  <= '0;
            ss_sy   <= 2'b11;
            mosi_sy <= '0;
            sck_d   <= 1'b0;
            ss_d    <= 1'b1;
        end else begin
            sck_sy  <= {sck_sy[0], sck};
            ss_sy   <= {ss_sy[0], ss};
            mosi_sy <= {mosi_sy[0], mosi};
            sck_d   <= sck_s;
            ss_d    <= ss_s;
        end
    end

    always_comb begin
        ss_fall  = ss_d & ~ss_s;
        ss_rise  = ~ss_d & ss_s;
        sck_rise = ~sck_d & sck_s & ~ss_s;
        accept   = ss_rise && (cnt == 5'd16) && shift[VALID] && !tx_full;
        cap      = slot_in[VALID] && (pkt_dst(slot_in) == ADDR_W'(NODE_ID)) && !rx_full;
        inj      = !cap && !slot_in[VALID] && tx_full;
        dst_ok   = int'(pkt_dst(tx_buf)) < N;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift    <= '0;
            cnt      <= '0;
            tx_buf   <= '0;
            rx_buf   <= '0;
            tx_full  <= 1'b0;
            rx_full  <= 1'b0;
            slot_out <= '0;
        end else begin
            if (ss_fall) begin
                shift   <= rx_full ? rx_buf : '0;
                rx_full <= 1'b0;
                cnt     <= '0;
            end else if (sck_rise) begin
                shift <= {shift[PKT_W-2:0], mosi_s};
                if (cnt != 5'h1f) cnt <= cnt + 5'd1;
            end
            if (accept) begin
                tx_buf  <= shift;
                tx_full <= 1'b1;
            end
            // Capture is gated on the registered rx_full, so a same-cycle drain wins.
            if (cap) begin
                rx_buf   <= slot_in;
                rx_full  <= 1'b1;
                slot_out <= '0;
            end else if (inj) begin
                tx_full  <= 1'b0;
                slot_out <= dst_ok ? pkt_stamp_src(tx_buf, ADDR_W'(NODE_ID)) : '0;
            end else begin
                slot_out <= slot_in;
            end
        end
    end

    // ss_d low too, so the stale shift word never leaks in the cycle before the load.
    assign miso  = ~ss_s & ~ss_d & shift[PKT_W-1];
    assign txrdy = ~tx_full;
    assign rxrdy = rx_full;
endmodule

// File: rtl/spinet.sv
// spinet top: N SPI-slave nodes joined by a unidirectional ring of 16-bit slots.
// slot[k] is registered in node k and feeds node (k+1) mod N.
module spinet
    import spinet_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] mosi,
    input  logic [N-1:0] sck,
    input  logic [N-1:0] ss,
    output logic [N-1:0] miso,
    output logic [N-1:0] txrdy,
    output logic [N-1:0] rxrdy
);
    logic [PKT_W-1:0] slot [N];

    for (genvar k = 0; k < N; k++) begin : g_node
        localparam int PREV = (k + N - 1) % N;
        spinet_node #(.N(N), .NODE_ID(k)) u_node (
            .clk      (clk),
            .reset    (reset),
            .mosi     (mosi[k]),
            .sck      (sck[k]),
            .ss       (ss[k]),
            .miso     (miso[k]),
            .txrdy    (txrdy[k]),
            .rxrdy    (rxrdy[k]),
            .slot_in  (slot[PREV]),
            .slot_out (slot[k])
        );
    end
endmodule

// File: tb/tb_spinet.sv
// Directed bench for spinet (N=6): SPI read words go through a scoreboard,
// flag behaviour is checked inline.
module tb_spinet;
    localparam int N = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] mosi = '0, sck = '0, ss = '1;
    logic [N-1:0] miso, txrdy, rxrdy;

    spinet #(.N(N)) dut (
        .clk(clk), .reset(reset), .mosi(mosi), .sck(sck), .ss(ss),
        .miso(miso), .txrdy(txrdy), .rxrdy(rxrdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [15:0] w;
    } sb_t;

    sb_t         exp_q[$];
    logic [15:0] obs_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] rd;
    logic [6:0]  mask;
    int          bad;
    logic        b;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every observed SPI read word is matched in order.
    initial begin
        sb_t         e;
        logic [15:0] o;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected actual=%h required=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e.w) begin
                        failures++;
                        $display("FAIL %s actual=%h required=%h", e.nm, o, e.w);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_begin(input int n);
        tick(4);
        ss[n] = 1'b0;
        tick(4);
    endtask

    task automatic spi_bit(input int n, input logic bi, output logic m);
        mosi[n] = bi;
        tick(3);
        sck[n] = 1'b1;
        m = miso[n];
        tick(3);
        sck[n] = 1'b0;
    endtask

    task automatic spi_end(input int n);
        tick(3);
        ss[n] = 1'b1;
        tick(1);
    endtask

    task automatic xfer(input int n, input logic [15:0] w, input int nbits, input bit chk,
                        input logic [15:0] exp, input string nm, output logic [15:0] r);
        logic m;
        r = '0;
        if (chk) exp_q.push_back('{nm, exp});
        spi_begin(n);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(n, w[15-i], m);
            r = {r[14:0], m};
        end
        spi_end(n);
        if (chk) obs_q.push_back(r);
    endtask

    // which: 0 = rxrdy, 1 = txrdy
    task automatic wait_flag(input string nm, input int which, input int n, input int budget);
        int k = 0;
        while (((which == 0) ? rxrdy[n] : txrdy[n]) !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(nm, (which == 0) ? rxrdy[n] : txrdy[n], 1);
    endtask

    initial begin
        logic [7:0] pl;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("reset_txrdy", txrdy, 6'h3f);
        check("reset_rxrdy", rxrdy, 6'h00);
        check("reset_miso", miso, 6'h00);

        // Basic delivery 0 -> 1 with source stamping.
        xfer(0, 16'h8940, 16, 1, 16'h0000, "n0_first_read", rd);
        wait_flag("n1_rxrdy", 0, 1, 10);
        check("n0_txrdy_back", txrdy[0], 1);
        xfer(1, 16'h0000, 16, 1, 16'h8840, "n1_read", rd);
        tick(2);
        check("n1_rxrdy_fall", rxrdy[1], 0);

        // Echo: node d reads and, in the same transfer, returns a packet to node 0.
        for (int d = 1; d <= 5; d++) begin
            pl = 8'(16 + d);
            xfer(0, {1'b1, 1'b0, 3'(d), 3'b000, pl}, 16, 1,
                 (d == 1) ? 16'h0000 : {1'b1, 1'b0, 3'b000, 3'(d - 1), 8'(15 + d)},
                 "n0_send_read", rd);
            wait_flag("echo_rxrdy", 0, d, 15);
            xfer(d, {1'b1, 1'b0, 3'b000, 3'(d), pl}, 16, 1,
                 {1'b1, 1'b0, 3'(d), 3'b000, pl}, "echo_read", rd);
            wait_flag("n0_rxrdy", 0, 0, 20);
        end
        xfer(0, 16'h0000, 16, 1, 16'h8515, "n0_last_read", rd);

        // Node 2 full: node 3's packet circulates until node 2 is read.
        xfer(0, 16'h9001, 16, 1, 16'h0000, "n0_read_empty", rd);
        wait_flag("n2_rxrdy", 0, 2, 15);
        xfer(3, 16'h9033, 16, 0, 16'h0000, "", rd);
        tick(30);
        check("circ_rxrdy", rxrdy, 6'b000100);
        check("circ_txrdy", txrdy, 6'h3f);
        xfer(2, 16'h0000, 16, 1, 16'h9001, "n2_read1", rd);
        wait_flag("n2_rxrdy_again", 0, 2, 20);
        xfer(2, 16'h0000, 16, 1, 16'h9333, "n2_read2", rd);

        // Discards: bit15=0 and a 12-bit transfer; dest 7 accepted then dropped.
        xfer(4, 16'h2D12, 16, 0, 16'h0000, "", rd);
        tick(2);
        check("bit15_zero_txrdy", txrdy[4], 1);
        xfer(4, 16'hA812, 12, 0, 16'h0000, "", rd);
        tick(2);
        check("short_xfer_txrdy", txrdy[4], 1);
        xfer(5, 16'hB855, 16, 0, 16'h0000, "", rd);
        tick(2);
        check("dest7_accepted", txrdy[5], 0);
        wait_flag("dest7_txrdy", 1, 5, 10);
        tick(40);
        check("discard_rxrdy", rxrdy, 6'h00);

        // Fill all six slots with packets for full node 2, then a stuck tx word
        // and a rejected write while txrdy=0.
        xfer(1, 16'h91A0, 16, 0, 16'h0000, "", rd);
        wait_flag("fill_n2_rxrdy", 0, 2, 15);
        for (int i = 0; i < 6; i++) begin
            xfer(0, 16'h90B0 + 16'(i), 16, 0, 16'h0000, "", rd);
            wait_flag("fill_inject", 1, 0, 20);
        end
        xfer(0, 16'h90B6, 16, 0, 16'h0000, "", rd);
        tick(20);
        check("ring_full_txrdy", txrdy[0], 0);
        xfer(0, 16'h90B7, 16, 0, 16'h0000, "", rd);
        check("ring_full_rxrdy", rxrdy, 6'b000100);
        xfer(2, 16'h0000, 16, 1, 16'h91A0, "drain_first", rd);
        mask = '0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            wait_flag("drain_rxrdy", 0, 2, 20);
            xfer(2, 16'h0000, 16, 0, 16'h0000, "", rd);
            if (rd[15:8] == 8'h90 && rd[7:0] >= 8'hB0 && rd[7:0] <= 8'hB6 && !mask[rd[2:0]])
                mask[rd[2:0]] = 1'b1;
            else
                bad++;
        end
        check("drain_mask", mask, 7'h7f);
        check("drain_bad", bad, 0);
        tick(40);
        check("drain_rxrdy_end", rxrdy, 6'h00);
        check("drain_txrdy_end", txrdy, 6'h3f);

        // Reset during an SPI transfer and with a packet circulating.
        xfer(2, 16'h9822, 16, 0, 16'h0000, "", rd);
        wait_flag("n3_rxrdy", 0, 3, 15);
        xfer(1, 16'h9811, 16, 0, 16'h0000, "", rd);
        tick(15);
        spi_begin(0);
        for (int i = 0; i < 8; i++) spi_bit(0, rd[0] ^ rd[0] ^ (i == 0), b);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("mid_reset_txrdy", txrdy, 6'h3f);
        check("mid_reset_rxrdy", rxrdy, 6'h00);
        check("mid_reset_miso", miso, 6'h00);
        for (int i = 0; i < 8; i++) spi_bit(0, 1'b0, b);
        spi_end(0);
        tick(40);
        check("post_reset_rxrdy", rxrdy, 6'h00);
        check("post_reset_txrdy", txrdy, 6'h3f);
        xfer(0, 16'h9877, 16, 1, 16'h0000, "post_reset_n0_read", rd);
        wait_flag("post_reset_n3_rxrdy", 0, 3, 10);
        xfer(3, 16'h0000, 16, 1, 16'h9877, "post_reset_n3_read", rd);

        tick(3);
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
